// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm annunciator: FSM states, source codes, lamp bit positions.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALERT    = 2'd1,
    ST_SILENCED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_RAIN    = 2'd1,
    SRC_BURGLAR = 2'd2,
    SRC_FIRE    = 2'd3
  } src_e;

  localparam int unsigned LAMP_W       = 3;
  localparam int unsigned LAMP_RAIN    = 0;
  localparam int unsigned LAMP_BURGLAR = 1;
  localparam int unsigned LAMP_FIRE    = 2;

  // Highest-priority latched source.
  function automatic src_e prio_src(input logic [LAMP_W-1:0] l);
    if (l[LAMP_FIRE])         return SRC_FIRE;
    else if (l[LAMP_BURGLAR]) return SRC_BURGLAR;
    else if (l[LAMP_RAIN])    return SRC_RAIN;
    else                      return SRC_NONE;
  endfunction

endpackage

// File: rtl/siren_pattern_gen.sv
// Siren pattern generator: owns the pattern counter and produces the registered siren drive
// for the currently active source (fire steady, burglar 50% duty, rain 25% duty).
module siren_pattern_gen
  import alarm_pkg::*;
#(
  parameter int unsigned BEEP_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       restart,
  input  logic [1:0] src,
  output logic       siren
);

  localparam int unsigned CNT_W = $clog2(4 * BEEP_HALF);
  localparam int unsigned PER_B = 2 * BEEP_HALF;
  localparam int unsigned PER_R = 4 * BEEP_HALF;

  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic             siren_q, siren_d;

  // Counter value for the coming cycle, then the pattern bit at that position.
  always_comb begin
    cnt_d   = '0;
    siren_d = 1'b0;
    last    = (src == SRC_BURGLAR) ? CNT_W'(PER_B - 1) : CNT_W'(PER_R - 1);
    if (en) begin
      if (!restart && (cnt_q != last)) cnt_d = cnt_q + CNT_W'(1);
      case (src)
        SRC_FIRE:              siren_d = 1'b1;
        SRC_BURGLAR, SRC_RAIN: siren_d = (cnt_d < CNT_W'(BEEP_HALF));
        default:               siren_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      siren_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      siren_q <= siren_d;
    end
  end

  assign siren = siren_q;

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: latches fire/burglar/rain levels, runs the ack/silence FSM and drives the siren.
// Optional escalation to call_out is built when ALARM_ESCALATE_EN is defined.
module alarm_annunciator
  import alarm_pkg::*;
#(
  parameter int unsigned BEEP_HALF  = 4,
  parameter int unsigned ESC_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_alarm,
  input  logic       burglar_alarm,
  input  logic       rain_alarm,
  input  logic       ack,
  output logic       siren,
  output logic [2:0] lamp,
  output logic [1:0] active_src,
  output logic [1:0] state,
  output logic       call_out
);

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [LAMP_W-1:0]  latch_q, latch_d;
  logic [LAMP_W-1:0]  ack_mask_q, ack_mask_d;
  logic [LAMP_W-1:0]  in_vec;
  logic               new_src;
  logic               restart;
  logic               siren_en;

  assign in_vec = {fire_alarm, burglar_alarm, rain_alarm};

  // Next state, latch and ack mask; latch bits can only drop while silenced.
  always_comb begin
    state_d    = state_q;
    ack_mask_d = ack_mask_q;
    new_src    = |(in_vec & ~ack_mask_q);
    latch_d    = (state_q == ST_SILENCED) ? in_vec : (latch_q | in_vec);
    case (state_q)
      ST_IDLE: begin
        if (|in_vec) state_d = ST_ALERT;
      end
      ST_ALERT: begin
        if (ack && !new_src) begin
          state_d    = ST_SILENCED;
          ack_mask_d = latch_q | in_vec;
        end
      end
      ST_SILENCED: begin
        if (new_src) begin
          state_d    = ST_ALERT;
          ack_mask_d = '0;
        end else if (latch_d == '0) begin
          state_d    = ST_IDLE;
          ack_mask_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ack_mask_d = '0;
      end
    endcase
    src_d    = prio_src(latch_d);
    siren_en = (state_d == ST_ALERT);
    restart  = siren_en && ((state_q != ST_ALERT) || (src_d != src_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      latch_q    <= '0;
      ack_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      latch_q    <= latch_d;
      ack_mask_q <= ack_mask_d;
    end
  end

  siren_pattern_gen #(
    .BEEP_HALF(BEEP_HALF)
  ) u_siren (
    .clk     (clk),
    .rst     (rst),
    .en      (siren_en),
    .restart (restart),
    .src     (src_d),
    .siren   (siren)
  );

  assign lamp       = latch_q;
  assign active_src = src_q;
  assign state      = state_q;

`ifdef ALARM_ESCALATE_EN
  localparam int unsigned ESC_W = $clog2(ESC_CYCLES + 1);

  logic [ESC_W-1:0] esc_q, esc_d;
  logic             call_q, call_d;

  // Saturating count of ALERT cycles; zeroed on entry, frozen elsewhere.
  always_comb begin
    esc_d  = esc_q;
    call_d = call_q;
    if (state_d == ST_ALERT && state_q != ST_ALERT) begin
      esc_d = '0;
    end else if (state_q == ST_ALERT && esc_q != ESC_W'(ESC_CYCLES)) begin
      esc_d = esc_q + ESC_W'(1);
    end
    if (state_q == ST_ALERT && state_d == ST_ALERT && esc_d == ESC_W'(ESC_CYCLES) &&
        (latch_d[LAMP_FIRE] || latch_d[LAMP_BURGLAR])) begin
      call_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      esc_q  <= '0;
      call_q <= 1'b0;
    end else begin
      esc_q  <= esc_d;
      call_q <= call_d;
    end
  end

  assign call_out = call_q;
`else
  logic unused_esc;
  assign unused_esc = ^ESC_CYCLES;
  assign call_out   = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_annunciator.sv
// Bench for alarm_annunciator: directed scenarios plus random traffic against a cycle-level
// behavioural model; escalation checks follow ALARM_ESCALATE_EN.
module tb_alarm_annunciator;

  localparam int BH  = 4;
  localparam int ESC = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fire_alarm = 1'b0, burglar_alarm = 1'b0, rain_alarm = 1'b0, ack = 1'b0;
  logic       siren, call_out;
  logic [2:0] lamp;
  logic [1:0] active_src, state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: state number, latch/mask vectors, cycles since pattern start.
  int         m_state, m_src, m_k, m_esc;
  logic [2:0] m_latch, m_mask;
  logic       m_siren, m_call;

  alarm_annunciator #(.BEEP_HALF(BH), .ESC_CYCLES(ESC)) dut (
    .clk(clk), .rst(rst), .fire_alarm(fire_alarm), .burglar_alarm(burglar_alarm),
    .rain_alarm(rain_alarm), .ack(ack), .siren(siren), .lamp(lamp),
    .active_src(active_src), .state(state), .call_out(call_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (observed running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] in, input logic a, input logic r);
    logic [2:0] nl;
    int ns, nsrc;
    bit newp;
    if (r) begin
      m_state = 0; m_latch = 3'b000; m_mask = 3'b000; m_src = 0;
      m_k = 0; m_siren = 1'b0; m_esc = 0; m_call = 1'b0;
    end else begin
      newp = ((in & ~m_mask) != 3'b000);
      nl   = (m_state == 2) ? in : (m_latch | in);
      ns   = m_state;
      if (m_state == 0 && in != 3'b000) ns = 1;
      else if (m_state == 1 && a && !newp) begin ns = 2; m_mask = m_latch | in; end
      else if (m_state == 2 && newp) begin ns = 1; m_mask = 3'b000; end
      else if (m_state == 2 && nl == 3'b000) begin ns = 0; m_mask = 3'b000; end
      nsrc = nl[2] ? 3 : (nl[1] ? 2 : (nl[0] ? 1 : 0));
      if (ns == 1) begin
        if (m_state != 1 || nsrc != m_src) m_k = 0;
        else m_k = m_k + 1;
        case (nsrc)
          3:       m_siren = 1'b1;
          2:       m_siren = ((m_k % (2 * BH)) < BH);
          1:       m_siren = ((m_k % (4 * BH)) < BH);
          default: m_siren = 1'b0;
        endcase
      end else begin
        m_k = 0;
        m_siren = 1'b0;
      end
`ifdef ALARM_ESCALATE_EN
      if (m_state == 1) m_esc = m_esc + 1;
      if (ns == 1 && m_state != 1) m_esc = 0;
      if (m_state == 1 && ns == 1 && m_esc >= ESC && (nl[2] || nl[1])) m_call = 1'b1;
`endif
      m_state = ns;
      m_latch = nl;
      m_src   = nsrc;
    end
  endtask

  // One clock: drive, advance model on the edge, compare just after it.
  task automatic cyc(input logic [2:0] in, input logic a, input logic r);
    {fire_alarm, burglar_alarm, rain_alarm} = in;
    ack = a;
    rst = r;
    @(posedge clk);
    model_step(in, a, r);
    #1;
    chk("state", 8'(state), 8'(m_state));
    chk("lamp", 8'(lamp), 8'(m_latch));
    chk("active_src", 8'(active_src), 8'(m_src));
    chk("siren", 8'(siren), 8'(m_siren));
    chk("call_out", 8'(call_out), 8'(m_call));
  endtask

  task automatic clear_all();
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] rin;
    logic       rack, rrst;
    model_step(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);
    chk("reset_state", 8'(state), 8'h00);
    chk("reset_siren", 8'(siren), 8'h00);

    // 1: reset in the middle of a fire alert
    cyc(3'b100, 1'b0, 1'b0);
    cyc(3'b100, 1'b0, 1'b1);
    chk("rst_mid_state", 8'(state), 8'h00);
    chk("rst_mid_lamp", 8'(lamp), 8'h00);
    cyc(3'b100, 1'b0, 1'b0);
    chk("rst_reenter", 8'(state), 8'h01);
    clear_all();

    // 2: single-cycle burglar pulse, pattern 1111_0000
    cyc(3'b010, 1'b0, 1'b0);
    chk("b_lamp", 8'(lamp), 8'h02);
    chk("b_src", 8'(active_src), 8'h02);
    chk("b_pat0", 8'(siren), 8'h01);
    for (int i = 1; i < 16; i++) begin
      cyc(3'b000, 1'b0, 1'b0);
      chk("b_pat", 8'(siren), 8'((i % 8) < 4));
    end
    chk("b_hold", 8'(lamp), 8'h02);
    clear_all();

    // 3: rain, then fire ten cycles later, then ack and clear
    for (int i = 0; i < 10; i++) cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b101, 1'b0, 1'b0);
    chk("rf_src", 8'(active_src), 8'h03);
    chk("rf_siren", 8'(siren), 8'h01);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    chk("rf_sil", 8'(state), 8'h02);
    chk("rf_sil_siren", 8'(siren), 8'h00);
    cyc(3'b000, 1'b0, 1'b0);
    chk("rf_idle", 8'(state), 8'h00);
    chk("rf_lamp", 8'(lamp), 8'h00);

    // 4: ack coinciding with a rising fire is ignored
    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b110, 1'b1, 1'b0);
    chk("ackfire_state", 8'(state), 8'h01);
    chk("ackfire_siren", 8'(siren), 8'h01);
    cyc(3'b110, 1'b0, 1'b0);
    chk("ackfire_siren2", 8'(siren), 8'h01);
    clear_all();

    // 5: silenced burglar still present, then rain re-alerts with a fresh pattern
    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    cyc(3'b010, 1'b0, 1'b0);
    chk("sil_lamp", 8'(lamp), 8'h02);
    chk("sil_state", 8'(state), 8'h02);
    cyc(3'b001, 1'b0, 1'b0);
    chk("rain_alert", 8'(state), 8'h01);
    chk("r_pat0", 8'(siren), 8'h01);
    for (int i = 1; i < 16; i++) begin
      cyc(3'b000, 1'b0, 1'b0);
      chk("r_pat", 8'(siren), 8'((i % 16) < 4));
    end
    clear_all();

    // 6: escalation with burglar unacknowledged, then rain alone after a reset
    cyc(3'b010, 1'b0, 1'b0);
    for (int i = 1; i < 70; i++) begin
      cyc(3'b000, 1'b0, 1'b0);
`ifdef ALARM_ESCALATE_EN
      chk("esc_burglar", 8'(call_out), 8'(i >= ESC));
`else
      chk("esc_off", 8'(call_out), 8'h00);
`endif
    end
    clear_all();
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b001, 1'b0, 1'b0);
    for (int i = 1; i < 70; i++) cyc(3'b000, 1'b0, 1'b0);
    chk("esc_rain", 8'(call_out), 8'h00);
    clear_all();

    // Random traffic, inputs mostly quiet so the FSM reaches every state
    for (int i = 0; i < 1500; i++) begin
      rin  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rack = ($urandom_range(0, 2) == 0);
      rrst = ($urandom_range(0, 199) == 0);
      cyc(rin, rack, rrst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
